// File: rtl/pong_pkg.sv
// Shared definitions for the pong core.
// Holds the ball sequencer state encoding, the default screen geometry,
// the centre coordinates, the direction encoding and the coordinate widths.
package pong_pkg;

  localparam int S_WIDTH  = 640;
  localparam int S_HEIGHT = 480;
  localparam int CENTRE_X = S_WIDTH / 2;
  localparam int CENTRE_Y = S_HEIGHT / 2;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  // Direction bit: 0 moves toward larger coordinates (right/down).
  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  typedef enum logic [1:0] {
    SERVE    = 2'd0,
    PLAY     = 2'd1,
    GAMEOVER = 2'd2
  } state_e;

endpackage

// File: rtl/ball_axis.sv
// One axis of ball motion: signed step by SPEED in the given direction,
// then clamp into [LO, HI]. Purely combinational.
// Ports:
//   pos      current coordinate
//   dir      direction (DIR_POS / DIR_NEG)
//   next_pos stepped and clamped coordinate
module ball_axis
  import pong_pkg::*;
#(
  parameter int W     = 10,
  parameter int LO    = 5,
  parameter int HI    = 635,
  parameter int SPEED = 2
) (
  input  logic [W-1:0] pos,
  input  logic         dir,
  output logic [W-1:0] next_pos
);

  // One extra bit so a step below zero stays negative instead of wrapping.
  localparam logic signed [W:0] STEP = (W+1)'(SPEED);
  localparam logic signed [W:0] LO_S = (W+1)'(LO);
  localparam logic signed [W:0] HI_S = (W+1)'(HI);

  logic signed [W:0] pos_s;
  logic signed [W:0] sum;

  always_comb begin
    pos_s = $signed({1'b0, pos});
    sum   = (dir == DIR_POS) ? (pos_s + STEP) : (pos_s - STEP);
    if (sum < LO_S) begin
      next_pos = LO_S[W-1:0];
    end else if (sum > HI_S) begin
      next_pos = HI_S[W-1:0];
    end else begin
      next_pos = sum[W-1:0];
    end
  end

endmodule

// File: rtl/ball_ctrl.sv
// Frame-rate ball sequencer for the pong core: owns ball position,
// direction, serve delay and scores. Collision flags computed elsewhere
// from ball_x/ball_y are sampled here on frame_tick.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   frame_tick            one-cycle pulse per frame
//   start                 restarts the game from GAMEOVER
//   coll_p1/coll_p2       ball overlaps left/right paddle
//   coll_h/coll_v         ball at left-right / top-bottom window edge
//   ball_x, ball_y        ball centre
//   score1, score2        left / right player score
//   point                 one-cycle pulse when a point is awarded
//   game_over             high in GAMEOVER
// Internal 'state' is the FSM state for hierarchical observation.
module ball_ctrl #(
  parameter int S_WIDTH      = pong_pkg::S_WIDTH,
  parameter int S_HEIGHT     = pong_pkg::S_HEIGHT,
  parameter int BALL_W       = 10,
  parameter int BALL_H       = 10,
  parameter int SPEED        = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int MAX_SCORE    = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_tick,
  input  logic                    start,
  input  logic                    coll_p1,
  input  logic                    coll_p2,
  input  logic                    coll_h,
  input  logic                    coll_v,
  output logic [pong_pkg::X_W-1:0] ball_x,
  output logic [pong_pkg::Y_W-1:0] ball_y,
  output logic [3:0]              score1,
  output logic [3:0]              score2,
  output logic                    point,
  output logic                    game_over
);

  import pong_pkg::*;

  localparam int SERVE_LOAD = (SERVE_FRAMES < 1) ? 1 : SERVE_FRAMES;
  localparam int CNT_W      = $clog2(SERVE_LOAD + 1);

  localparam logic [X_W-1:0]   CX_V      = X_W'(S_WIDTH / 2);
  localparam logic [Y_W-1:0]   CY_V      = Y_W'(S_HEIGHT / 2);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SERVE_LOAD);
  localparam logic [3:0]       SCORE_MAX = 4'(MAX_SCORE);

  state_e           state;
  logic             dir_x;
  logic             dir_y;
  logic [CNT_W-1:0] serve_cnt;

  logic             bounce_p1;
  logic             bounce_p2;
  logic             miss;
  logic             left_miss;
  logic             dir_x_upd;
  logic             dir_y_upd;
  logic [3:0]       score1_inc;
  logic [3:0]       score2_inc;
  logic [X_W-1:0]   x_next;
  logic [Y_W-1:0]   y_next;

  // A paddle flag only counts while the ball moves toward that paddle,
  // so a ball still overlapping after a bounce cannot stick.
  always_comb begin
    bounce_p1  = coll_p1 && (dir_x == DIR_NEG);
    bounce_p2  = coll_p2 && (dir_x == DIR_POS);
    miss       = coll_h && !(bounce_p1 || bounce_p2);
    left_miss  = (ball_x < CX_V);
    score1_inc = score1 + 4'd1;
    score2_inc = score2 + 4'd1;

    dir_x_upd = dir_x;
    if (bounce_p1) begin
      dir_x_upd = DIR_POS;
    end else if (bounce_p2) begin
      dir_x_upd = DIR_NEG;
    end

    // Absolute, not a toggle: the half of the screen decides the new heading.
    dir_y_upd = dir_y;
    if (coll_v) begin
      dir_y_upd = (ball_y < CY_V) ? DIR_POS : DIR_NEG;
    end
  end

  ball_axis #(
    .W     (X_W),
    .LO    (BALL_W / 2),
    .HI    (S_WIDTH - BALL_W / 2),
    .SPEED (SPEED)
  ) u_axis_x (
    .pos      (ball_x),
    .dir      (dir_x_upd),
    .next_pos (x_next)
  );

  ball_axis #(
    .W     (Y_W),
    .LO    (BALL_H / 2),
    .HI    (S_HEIGHT - BALL_H / 2),
    .SPEED (SPEED)
  ) u_axis_y (
    .pos      (ball_y),
    .dir      (dir_y_upd),
    .next_pos (y_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SERVE;
      dir_x     <= DIR_POS;
      dir_y     <= DIR_POS;
      serve_cnt <= CNT_LOAD;
      ball_x    <= CX_V;
      ball_y    <= CY_V;
      score1    <= 4'd0;
      score2    <= 4'd0;
      point     <= 1'b0;
      game_over <= 1'b0;
    end else begin
      point <= 1'b0;
      case (state)
        SERVE: begin
          if (frame_tick) begin
            if (serve_cnt <= CNT_W'(1)) begin
              state <= PLAY;
            end else begin
              serve_cnt <= serve_cnt - CNT_W'(1);
            end
          end
        end
        PLAY: begin
          if (frame_tick) begin
            if (miss) begin
              point     <= 1'b1;
              ball_x    <= CX_V;
              ball_y    <= CY_V;
              serve_cnt <= CNT_LOAD;
              state     <= SERVE;
              // Next serve heads toward the player who lost the point.
              if (left_miss) begin
                score2 <= score2_inc;
                dir_x  <= DIR_NEG;
                if (score2_inc == SCORE_MAX) begin
                  state     <= GAMEOVER;
                  game_over <= 1'b1;
                end
              end else begin
                score1 <= score1_inc;
                dir_x  <= DIR_POS;
                if (score1_inc == SCORE_MAX) begin
                  state     <= GAMEOVER;
                  game_over <= 1'b1;
                end
              end
            end else begin
              dir_x  <= dir_x_upd;
              dir_y  <= dir_y_upd;
              ball_x <= x_next;
              ball_y <= y_next;
            end
          end
        end
        GAMEOVER: begin
          if (start) begin
            score1    <= 4'd0;
            score2    <= 4'd0;
            serve_cnt <= CNT_LOAD;
            dir_x     <= DIR_POS;
            game_over <= 1'b0;
            state     <= SERVE;
          end
        end
        default: begin
          state <= SERVE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl. Each frame tick issued by the driver pushes the
// expected output word; the monitor pops and compares on the cycle after
// the tick edge. Non-tick events (reset, start) are checked directly.
module tb_ball_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       start;
  logic       coll_p1;
  logic       coll_p2;
  logic       coll_h;
  logic       coll_v;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [3:0] score1;
  logic [3:0] score2;
  logic       point;
  logic       game_over;

  ball_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .start      (start),
    .coll_p1    (coll_p1),
    .coll_p2    (coll_p2),
    .coll_h     (coll_h),
    .coll_v     (coll_v),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .score1     (score1),
    .score2     (score2),
    .point      (point),
    .game_over  (game_over)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [28:0] exp_q[$];
  logic [28:0] mon_e;
  logic        tick_seen;
  logic        chk_pt_low = 1'b0;

  // Expected-state tracking: position, direction (+1/-1), scores.
  int   cx, cy, dx, dy, s1, s2;
  logic go;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic pt);
    exp_q.push_back({10'(cx), 9'(cy), 4'(s1), 4'(s2), pt, go});
  endtask

  task automatic chk_now(input string tag, input logic pt);
    chk({tag, ".ball_x"},    32'(ball_x),    32'(cx));
    chk({tag, ".ball_y"},    32'(ball_y),    32'(cy));
    chk({tag, ".score1"},    32'(score1),    32'(s1));
    chk({tag, ".score2"},    32'(score2),    32'(s2));
    chk({tag, ".point"},     32'(point),     32'(pt));
    chk({tag, ".game_over"}, 32'(game_over), 32'(go));
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_seen <= 1'b0;
    else        tick_seen <= frame_tick;
  end

  always @(negedge clk) begin
    if (chk_pt_low) begin
      chk_pt_low = 1'b0;
      chk("point_one_cycle", 32'(point), 32'd0);
    end
    if (tick_seen === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_tick: got a tick with no expected entry (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ball_x",    32'(ball_x),    32'(mon_e[28:19]));
        chk("ball_y",    32'(ball_y),    32'(mon_e[18:10]));
        chk("score1",    32'(score1),    32'(mon_e[9:6]));
        chk("score2",    32'(score2),    32'(mon_e[5:2]));
        chk("point",     32'(point),     32'(mon_e[1]));
        chk("game_over", 32'(game_over), 32'(mon_e[0]));
        if (mon_e[1]) chk_pt_low = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input logic p1, input logic p2, input logic h, input logic v);
    @(negedge clk);
    frame_tick = 1'b1;
    coll_p1    = p1;
    coll_p2    = p2;
    coll_h     = h;
    coll_v     = v;
    @(negedge clk);
    frame_tick = 1'b0;
    coll_p1    = 1'b0;
    coll_p2    = 1'b0;
    coll_h     = 1'b0;
    coll_v     = 1'b0;
  endtask

  task automatic centre();
    cx = 320;
    cy = 240;
  endtask

  // Free motion with clamping to the window edge limits.
  task automatic step();
    cx = cx + 2 * dx;
    cy = cy + 2 * dy;
    if (cx < 5)   cx = 5;
    if (cx > 635) cx = 635;
    if (cy < 5)   cy = 5;
    if (cy > 475) cy = 475;
  endtask

  task automatic serve_wait();
    repeat (60) begin
      push(1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic plain();
    step();
    push(1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    start      = 1'b0;
    coll_p1    = 1'b0;
    coll_p2    = 1'b0;
    coll_h     = 1'b0;
    coll_v     = 1'b0;
    centre();
    dx = 1; dy = 1; s1 = 0; s2 = 0; go = 1'b0;

    repeat (2) @(negedge clk);
    chk_now("reset", 1'b0);
    rst_n = 1'b1;

    // Serve delay: 60 ticks at centre, first move on tick 61.
    serve_wait();
    plain();                                  // (322,242)

    // Right paddle turns the ball; holding it while moving away is ignored.
    dx = -1; step(); push(1'b0); tick(1'b0, 1'b1, 1'b0, 1'b0);   // (320,244)
    step(); push(1'b0); tick(1'b0, 1'b1, 1'b0, 1'b0);            // (318,246)

    // Left paddle with dir_x=- turns right; held 3 more ticks, no re-reversal.
    dx = 1; step(); push(1'b0); tick(1'b1, 1'b0, 1'b0, 1'b0);    // (320,248)
    repeat (3) begin
      step(); push(1'b0); tick(1'b1, 1'b0, 1'b0, 1'b0);
    end                                                          // (326,254)

    // Run down to the bottom limit (475, clamped), then bottom wall.
    for (int i = 0; i < 400 && cy != 475; i++) plain();
    dy = -1; step(); push(1'b0); tick(1'b0, 1'b0, 1'b0, 1'b1);   // y=473

    // Run up to y=5 (x clamps at 635 on the way), then top wall.
    for (int i = 0; i < 400 && cy != 5; i++) plain();
    dy = 1; step(); push(1'b0); tick(1'b0, 1'b0, 1'b0, 1'b1);    // (635,7)

    // Paddle bounce + window edge + top wall on one tick: bounce, no point.
    dx = -1; step(); push(1'b0); tick(1'b0, 1'b1, 1'b1, 1'b1);   // (633,9)

    // Run left to x=5 and miss on the left: right player scores.
    for (int i = 0; i < 400 && cx != 5; i++) plain();
    s2 = 1; centre(); dx = -1; push(1'b1); tick(1'b0, 1'b0, 1'b1, 1'b0);

    // Serve heads toward the loser: first move x=318.
    serve_wait();
    plain();                                  // (318,242)

    // Corner (edge + wall, no paddle) is a point only.
    s2 = 2; centre(); dx = -1; push(1'b1); tick(1'b0, 1'b0, 1'b1, 1'b1);

    // Bounce back to x=320 then miss there: x==centre scores for the left player.
    serve_wait();
    dx = 1; step(); push(1'b0); tick(1'b1, 1'b0, 1'b0, 1'b0);    // (320,242)
    s1 = 1; centre(); dx = 1; push(1'b1); tick(1'b0, 1'b0, 1'b1, 1'b0);

    // Right-side misses up to MAX_SCORE, last one ends the game.
    for (int k = 0; k < 8; k++) begin
      serve_wait();
      plain();                                // (322,242)
      s1 = s1 + 1;
      centre();
      go = (s1 == 9);
      push(1'b1);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
    end

    // GAMEOVER ignores ticks and collision flags.
    repeat (3) begin
      push(1'b0);
      tick(1'b1, 1'b1, 1'b1, 1'b1);
    end

    // start without a frame tick restarts the game.
    chk("game_over_before_start", 32'(game_over), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s1 = 0; s2 = 0; go = 1'b0;
    chk_now("after_start", 1'b0);
    dx = 1;
    serve_wait();
    plain();                                  // (322,242)
    plain();
    plain();                                  // (326,246)

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    centre();
    dx = 1; dy = 1; s1 = 0; s2 = 0; go = 1'b0;
    chk_now("async_reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Serve counter reloaded by reset.
    serve_wait();
    plain();                                  // (322,242)

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
